// File: rtl/sy_ppl_fpu_wb.sv
// FPU writeback: in-order destination tags and results are paired at the FIFO head and retired
// to the FP or integer register file, with each result's exception flags OR-ed into fflags.
module sy_ppl_fpu_wb #(
    parameter int DEPTH = 4,
    parameter int FLEN  = 64,
    parameter int DWTH  = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            dec_fwb__issue_i,
    input  logic [4:0]      dec_fwb__rd_idx_i,
    input  logic            dec_fwb__rd_is_int_i,
    input  logic            dec_fwb__nan_box_i,
    output logic            fwb_dec__full_o,
    output logic            fwb_dec__busy_o,
    input  logic            fpu_fwb__valid_i,
    input  logic [FLEN-1:0] fpu_fwb__result_i,
    input  logic [4:0]      fpu_fwb__status_i,
    output logic            fwb_frf__we_o,
    output logic [4:0]      fwb_frf__waddr_o,
    output logic [FLEN-1:0] fwb_frf__wdata_o,
    output logic            fwb_xrf__we_o,
    output logic [4:0]      fwb_xrf__waddr_o,
    output logic [DWTH-1:0] fwb_xrf__wdata_o,
    input  logic            xrf_fwb__ready_i,
    output logic            fwb_csr__fflags_we_o,
    output logic [4:0]      fwb_csr__fflags_o,
    output logic            fwb__err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [4:0]      tag_idx_mem  [DEPTH];
    logic            tag_int_mem  [DEPTH];
    logic            tag_nb_mem   [DEPTH];
    logic [FLEN-1:0] res_data_mem [DEPTH];
    logic [4:0]      res_stat_mem [DEPTH];

    logic [PTR_W-1:0] tag_wr_ptr_reg;
    logic [PTR_W-1:0] res_wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] cnt_issued_reg;
    logic [CNT_W-1:0] cnt_res_reg;
    logic             err_reg;

    logic            head_valid;
    logic            head_int;
    logic            head_nb;
    logic [4:0]      head_idx;
    logic [FLEN-1:0] head_data;
    logic [4:0]      head_stat;
    logic            retire;
    logic            full;
    logic            issue_ok;
    logic            issue_err;
    logic            res_orphan;
    logic            res_ok;
    logic            res_err;

    // A head entry is only meaningful once its result has arrived; tags alone never retire.
    assign head_valid = (cnt_res_reg != '0);
    assign head_int   = tag_int_mem[rd_ptr_reg];
    assign head_nb    = tag_nb_mem[rd_ptr_reg];
    assign head_idx   = tag_idx_mem[rd_ptr_reg];
    assign head_data  = res_data_mem[rd_ptr_reg];
    assign head_stat  = res_stat_mem[rd_ptr_reg];

    assign retire     = head_valid && !flush_i && (!head_int || xrf_fwb__ready_i);
    assign full       = (cnt_issued_reg == CNT_W'(DEPTH));
    assign issue_ok   = dec_fwb__issue_i && !flush_i && (!full || retire);
    assign issue_err  = dec_fwb__issue_i && !flush_i && full && !retire;
    assign res_orphan = (cnt_res_reg == cnt_issued_reg);
    assign res_ok     = fpu_fwb__valid_i && !flush_i && !res_orphan;
    assign res_err    = fpu_fwb__valid_i && !flush_i && res_orphan;

    always_ff @(posedge clk_i) begin
        if (issue_ok) begin
            tag_idx_mem[tag_wr_ptr_reg] <= dec_fwb__rd_idx_i;
            tag_int_mem[tag_wr_ptr_reg] <= dec_fwb__rd_is_int_i;
            tag_nb_mem[tag_wr_ptr_reg]  <= dec_fwb__nan_box_i;
        end
        if (res_ok) begin
            res_data_mem[res_wr_ptr_reg] <= fpu_fwb__result_i;
            res_stat_mem[res_wr_ptr_reg] <= fpu_fwb__status_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_wr_ptr_reg <= '0;
            res_wr_ptr_reg <= '0;
            rd_ptr_reg     <= '0;
            cnt_issued_reg <= '0;
            cnt_res_reg    <= '0;
            err_reg        <= 1'b0;
        end else begin
            err_reg <= err_reg | issue_err | res_err;
            if (flush_i) begin
                tag_wr_ptr_reg <= '0;
                res_wr_ptr_reg <= '0;
                rd_ptr_reg     <= '0;
                cnt_issued_reg <= '0;
                cnt_res_reg    <= '0;
            end else begin
                if (issue_ok) tag_wr_ptr_reg <= tag_wr_ptr_reg + PTR_W'(1);
                if (res_ok)   res_wr_ptr_reg <= res_wr_ptr_reg + PTR_W'(1);
                if (retire)   rd_ptr_reg     <= rd_ptr_reg + PTR_W'(1);
                cnt_issued_reg <= cnt_issued_reg + CNT_W'(issue_ok) - CNT_W'(retire);
                cnt_res_reg    <= cnt_res_reg + CNT_W'(res_ok) - CNT_W'(retire);
            end
        end
    end

    // Write ports depend only on registered head state; the integer request holds until granted.
    assign fwb_frf__we_o    = head_valid && !head_int;
    assign fwb_frf__waddr_o = fwb_frf__we_o ? head_idx : 5'd0;
    assign fwb_frf__wdata_o = !fwb_frf__we_o ? '0 :
                              head_nb ? {{(FLEN-32){1'b1}}, head_data[31:0]} : head_data;

    assign fwb_xrf__we_o    = head_valid && head_int;
    assign fwb_xrf__waddr_o = fwb_xrf__we_o ? head_idx : 5'd0;
    assign fwb_xrf__wdata_o = fwb_xrf__we_o ? head_data[DWTH-1:0] : '0;

    assign fwb_csr__fflags_we_o = retire;
    assign fwb_csr__fflags_o    = retire ? head_stat : 5'd0;

    assign fwb_dec__full_o = full;
    assign fwb_dec__busy_o = (cnt_issued_reg != '0);
    assign fwb__err_o      = err_reg;

endmodule

// File: doc/sy_ppl_fpu_wb.md
# sy_ppl_fpu_wb

FPU writeback stage, directly downstream of the FPU pipeline wrapper. Records each FP op's destination at issue in an in-order tag FIFO. Buffers FPU results, which arrive in order and cannot be back-pressured, in a matching result FIFO. Retires each result to the FP or integer register file and accumulates its exception flags into the CSR fflags field.

## Interface
- DEPTH, 4: max outstanding FP ops; power of 2, ≥2
- FLEN / DWTH: from sy_pkg (64 / 64)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous and active-high
- flush_i  in  1  pipeline flush
- dec_fwb__issue_i  in  1  an op is accepted by the FPU this cycle (FPU valid&&ready)
- dec_fwb__rd_idx_i  in  5  destination register index
- dec_fwb__rd_is_int_i  in  1  destination is the integer RF (FCVT_F2I, FMV_F2X, FCLASS, compares)
- dec_fwb__nan_box_i  in  1  single-precision result; NaN-box on FP writes
- fwb_dec__full_o  out  1  DEPTH ops outstanding; decode must not issue
- fwb_dec__busy_o  out  1  any op outstanding
- fpu_fwb__valid_i  in  1  FPU result valid
- fpu_fwb__result_i  in  FLEN  FPU result
- fpu_fwb__status_i  in  5  FPU fflags {NV,DZ,OF,UF,NX}
- fwb_frf__we_o  out  1  FP RF write enable
- fwb_frf__waddr_o  out  5  FP RF write address
- fwb_frf__wdata_o  out  FLEN  FP RF write data
- fwb_xrf__we_o  out  1  integer RF write request
- fwb_xrf__waddr_o  out  5  integer RF write address
- fwb_xrf__wdata_o  out  DWTH  integer RF write data
- xrf_fwb__ready_i  in  1  integer write port granted this cycle (shared port)
- fwb_csr__fflags_we_o  out  1  fflags OR-update strobe
- fwb_csr__fflags_o  out  5  flags to OR into fflags
- fwb__err_o  out  1  sticky protocol error

## Operation
- Tag FIFO: DEPTH entries of {rd_idx, rd_is_int, nan_box}; written on issue_i.
- Result FIFO: DEPTH entries of {result, status}; written on fpu_fwb__valid_i. Separate write pointer; the read pointer is shared with the tag FIFO.
- Counters:
  - cnt_issued: tags held, width $clog2(DEPTH+1); +1 on issue, −1 on retire.
  - cnt_res: results held; +1 on valid_i, −1 on retire.
- Head is retire-eligible when cnt_res>0. Head has the FP destination (rd_is_int=0):
  - retires unconditionally.
  - frf_we=1; wdata = result, with [FLEN-1:32] forced to all ones when nan_box=1.
- Head has the integer destination:
  - xrf_we=1 while eligible.
  - retires only in a cycle where xrf_fwb__ready_i=1; otherwise holds, with outputs stable.
  - xrf wdata is the full result (no boxing).
- Retire pulses fflags_we=1 with fflags_o=head status, even when status=0.
- Pointers wrap modulo DEPTH.
- Outputs: full_o = (cnt_issued==DEPTH); busy_o = (cnt_issued!=0).
- Simultaneous events:
  - Issue + retire in one cycle: cnt_issued unchanged; legal when full.
  - Result arrival + retire in one cycle: cnt_res unchanged.
- flush_i: clears both FIFOs, pointers and counters in the same cycle. Nothing retires that cycle; an issue or result arriving that cycle is dropped.
- Errors set fwb__err_o, which is cleared only by reset:
  - issue_i while full and not retiring: the issue is ignored.
  - valid_i with cnt_res==cnt_issued, i.e. a result with no tag: the result is dropped.

## Timing
- Reset: all outputs 0; counters and pointers 0; err_o=0.
- Result at cycle N, head with FP destination → frf_we in cycle N+1. Integer destination → xrf_we from N+1 until the first cycle with ready.
- Back-to-back results retire at one per cycle when ports are free.
- full_o/busy_o are registered-count derived and update the cycle after the issue or retire.
- RF write outputs are combinational from the FIFO head, with no input-to-output combinational path.
- Reset asserted mid-operation empties everything immediately and asynchronously.

## Test plan
- Single-precision FADD to f3: issue, then result 0x3F800000 with status 0x01 one cycle later → next cycle frf_we=1, waddr=3, wdata=0xFFFFFFFF3F800000, fflags_we=1, fflags=0x01; busy_o falls the following cycle.
- FCVT_F2I to x5 with xrf ready held low 3 cycles, result 0x2A → xrf_we=1, waddr=5, wdata=0x2A held stable 3 cycles; retires on the ready cycle; fflags strobes once.
- 4 ops issued back-to-back (DEPTH=4) → full_o=1. In the cycle the first result retires, a 5th issue is accepted with no err, and full_o stays 1.
- Mixed FP/int order (f1, x2, f3) with ready low while x2 is head → f3 does not write before x2; the order of writes is preserved.
- 2 outstanding ops, flush_i coincident with the first result → no RF writes, no fflags strobe, busy_o=0 the next cycle, err_o=0.
- Result valid with nothing outstanding → dropped, err_o=1 and sticky until reset.
